// File: rtl/cla_seq_pkg.sv
// Shared definitions for the sequential carry-lookahead adder controller.
//   SLICE_W   : width of the single adder slice that is time-multiplexed
//   state_e   : controller FSM states (2-bit encoding)
//   idx_width : width of the slice index counter, never below 1 bit
package cla_seq_pkg;

  localparam int unsigned SLICE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // A single-slice build still needs a 1-bit index register.
  function automatic int unsigned idx_width(input int unsigned nslice);
    return (nslice > 1) ? $clog2(nslice) : 1;
  endfunction

endpackage

// File: rtl/cla_seq_adder_ctrl_cla4_slice.sv
// Combinational 4-bit carry-lookahead adder slice.
//   a_i, b_i : slice operands
//   ci_i     : carry into bit 0
//   s_c      : slice sum
//   co_c     : carry out of bit 3
module cla4_slice
  import cla_seq_pkg::*;
(
  input  logic [SLICE_W-1:0] a_i,
  input  logic [SLICE_W-1:0] b_i,
  input  logic               ci_i,
  output logic [SLICE_W-1:0] s_c,
  output logic               co_c
);

  logic [SLICE_W-1:0] g;
  logic [SLICE_W-1:0] p;
  logic [SLICE_W:0]   c;

  assign g = a_i & b_i;
  assign p = a_i ^ b_i;

  // Flattened lookahead equations: every carry depends only on g, p and ci_i.
  assign c[0] = ci_i;
  assign c[1] = g[0] | (p[0] & ci_i);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci_i);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & ci_i);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & ci_i);

  assign s_c  = p ^ c[SLICE_W-1:0];
  assign co_c = c[SLICE_W];

endmodule

// File: rtl/cla_seq_adder_ctrl.sv
// Sequencer that adds WIDTH-bit operands through one 4-bit CLA slice,
// one slice per cycle, LSB first, with the inter-slice carry registered.
// Optional macro CLA_SEQ_OVF_EN adds the two's-complement overflow output.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : operand handshake (a, b, ci captured on accept)
//   out_valid/out_ready : result handshake (sum, co[, ovf] stable while valid)
//   sum, co             : a+b+ci modulo 2^WIDTH and MSB-slice carry out
//   ovf                 : two's-complement overflow (CLA_SEQ_OVF_EN only)
module cla_seq_adder_ctrl
  import cla_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             co
`ifdef CLA_SEQ_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned NSLICE = WIDTH / SLICE_W;
  localparam int unsigned IDX_W  = idx_width(NSLICE);

  generate
    if (((WIDTH % SLICE_W) != 0) || (WIDTH < SLICE_W)) begin : g_bad_width
      $error("cla_seq_adder_ctrl: WIDTH must be a non-zero multiple of 4");
    end
  endgenerate

  // Operands and sum viewed as an array of slices for index-based access.
  typedef logic [NSLICE-1:0][SLICE_W-1:0] word_t;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  word_t              a_q, a_d;
  word_t              b_q, b_d;
  word_t              sum_q, sum_d;
  logic               co_q, co_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;

  logic [SLICE_W-1:0] slice_a_c;
  logic [SLICE_W-1:0] slice_b_c;
  logic [SLICE_W-1:0] slice_s_c;
  logic               slice_co_c;
  logic               last_slice_c;

`ifdef CLA_SEQ_OVF_EN
  logic               ovf_q, ovf_d;
  logic               msb_cin_c;
`endif

  assign slice_a_c    = a_q[idx_q];
  assign slice_b_c    = b_q[idx_q];
  assign last_slice_c = (idx_q == IDX_W'(NSLICE - 1));

  // Single shared adder slice.
  cla4_slice u_slice (
    .a_i  (slice_a_c),
    .b_i  (slice_b_c),
    .ci_i (carry_q),
    .s_c  (slice_s_c),
    .co_c (slice_co_c)
  );

`ifdef CLA_SEQ_OVF_EN
  // Carry into the top bit recovered from that bit's sum: s = a ^ b ^ cin.
  assign msb_cin_c = slice_a_c[SLICE_W-1] ^ slice_b_c[SLICE_W-1] ^ slice_s_c[SLICE_W-1];
`endif

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      co_q        <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef CLA_SEQ_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      co_q        <= co_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
`ifdef CLA_SEQ_OVF_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    co_d        = co_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
`ifdef CLA_SEQ_OVF_EN
    ovf_d       = ovf_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          a_d        = a;
          b_d        = b;
          carry_d    = ci;
          idx_d      = '0;
          in_ready_d = 1'b0;
          state_d    = ST_RUN;
        end
      end

      ST_RUN: begin
        sum_d[idx_q] = slice_s_c;
        carry_d      = slice_co_c;
        if (last_slice_c) begin
          co_d        = slice_co_c;
`ifdef CLA_SEQ_OVF_EN
          ovf_d       = msb_cin_c ^ slice_co_c;
`endif
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end

      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = ST_IDLE;
      end
    endcase
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign co        = co_q;
`ifdef CLA_SEQ_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_cla_seq_adder_ctrl.sv
// Directed bench for cla_seq_adder_ctrl (WIDTH=16, plus WIDTH=8 with CLA_SEQ_OVF_EN).
module tb_cla_seq_adder_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        ci;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        co;
`ifdef CLA_SEQ_OVF_EN
  logic        ovf;
  logic        in_valid8, in_ready8, out_valid8, co8, ovf8;
  logic [7:0]  a8, b8, sum8;
`endif

  int n_checks;
  int n_errors;

  cla_seq_adder_ctrl #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .ci        (ci),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .co        (co)
`ifdef CLA_SEQ_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

`ifdef CLA_SEQ_OVF_EN
  cla_seq_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .a         (a8),
    .b         (b8),
    .ci        (1'b0),
    .out_valid (out_valid8),
    .out_ready (1'b1),
    .sum       (sum8),
    .co        (co8),
    .ovf       (ovf8)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept one operand set, check latency/busy/result, then complete the handshake.
  task automatic do_op(input logic [15:0] va, input logic [15:0] vb, input logic vci,
                       input logic [15:0] exp_sum, input logic exp_co, input logic exp_ovf);
    int lat;
    int guard;
    guard = 0;
    while (!in_ready && guard < 20) begin
      step();
      guard++;
    end
    check_eq("op_ready_before", 32'(in_ready), 32'd1);
    a = va; b = vb; ci = vci; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check_eq("op_busy_after_accept", 32'(in_ready), 32'd0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      check_eq("op_busy_in_run", 32'(in_ready), 32'd0);
      step();
      lat++;
    end
    check_eq("op_latency", 32'(lat), 32'd4);
    check_eq("op_sum", 32'(sum), 32'(exp_sum));
    check_eq("op_co", 32'(co), 32'(exp_co));
`ifdef CLA_SEQ_OVF_EN
    check_eq("op_ovf", 32'(ovf), 32'(exp_ovf));
`else
    if (exp_ovf) begin end
`endif
    check_eq("op_busy_in_done", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check_eq("op_valid_dropped", 32'(out_valid), 32'd0);
    check_eq("op_ready_back", 32'(in_ready), 32'd1);
  endtask

  logic [15:0] va_t [3];
  logic [15:0] vb_t [3];
  logic        vc_t [3];
  logic [15:0] es_t [3];
  logic        ec_t [3];
  int          acc_cyc [3];

  initial begin
    int n_acc;
    int n_res;
    int cyc;
    logic acc_now;
    n_checks = 0; n_errors = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; ci = 1'b0;
`ifdef CLA_SEQ_OVF_EN
    in_valid8 = 1'b0; a8 = '0; b8 = '0;
`endif
    #12;
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_sum", 32'(sum), 32'd0);
    check_eq("rst_co", 32'(co), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Full ripple of the carry through every slice.
    do_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    // Carry-in used as the LSB carry.
    do_op(16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0);

    // Backpressure: result must hold and a new request must wait.
    a = 16'h00AA; b = 16'h0055; ci = 1'b0; in_valid = 1'b1;
    step();
    a = 16'h0001; b = 16'h0002;
    for (int i = 0; i < 4; i++) step();
    check_eq("bp_valid_up", 32'(out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("bp_valid_hold", 32'(out_valid), 32'd1);
      check_eq("bp_sum_hold", 32'(sum), 32'h00FF);
      check_eq("bp_co_hold", 32'(co), 32'd0);
      check_eq("bp_no_accept", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check_eq("bp_ready_back", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    check_eq("bp_second_accept", 32'(in_ready), 32'd0);
    for (int i = 0; i < 4; i++) step();
    check_eq("bp_second_valid", 32'(out_valid), 32'd1);
    check_eq("bp_second_sum", 32'(sum), 32'h0003);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Reset pulse in the middle of a run (index 2).
    a = 16'h1111; b = 16'h2222; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    check_eq("midrst_in_ready", 32'(in_ready), 32'd1);
    check_eq("midrst_out_valid", 32'(out_valid), 32'd0);
    check_eq("midrst_sum", 32'(sum), 32'd0);
    check_eq("midrst_co", 32'(co), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    do_op(16'h00FF, 16'h0F01, 1'b0, 16'h1000, 1'b0, 1'b0);

    // Back-to-back with both valid and ready held high.
    va_t = '{16'hAAAA, 16'h8000, 16'h0F0F};
    vb_t = '{16'h5555, 16'h8000, 16'h0101};
    vc_t = '{1'b1, 1'b0, 1'b0};
    es_t = '{16'h0000, 16'h0000, 16'h1010};
    ec_t = '{1'b1, 1'b1, 1'b0};
    n_acc = 0; n_res = 0; cyc = 0;
    a = va_t[0]; b = vb_t[0]; ci = vc_t[0];
    in_valid = 1'b1; out_ready = 1'b1;
    while (n_res < 3 && cyc < 60) begin
      acc_now = in_ready && in_valid;
      if (out_valid) begin
        check_eq("b2b_sum", 32'(sum), 32'(es_t[n_res]));
        check_eq("b2b_co", 32'(co), 32'(ec_t[n_res]));
        n_res++;
      end
      step();
      cyc++;
      if (acc_now) begin
        acc_cyc[n_acc] = cyc;
        n_acc++;
        if (n_acc < 3) begin
          a = va_t[n_acc]; b = vb_t[n_acc]; ci = vc_t[n_acc];
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    out_ready = 1'b0;
    check_eq("b2b_results", 32'(n_res), 32'd3);
    check_eq("b2b_accepts", 32'(n_acc), 32'd3);
    check_eq("b2b_gap01", 32'(acc_cyc[1] - acc_cyc[0]), 32'd6);
    check_eq("b2b_gap12", 32'(acc_cyc[2] - acc_cyc[1]), 32'd6);

`ifdef CLA_SEQ_OVF_EN
    do_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    do_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    a8 = 8'h80; b8 = 8'h80; in_valid8 = 1'b1;
    step();
    in_valid8 = 1'b0;
    cyc = 0;
    while (!out_valid8 && cyc < 20) begin
      step();
      cyc++;
    end
    check_eq("w8_latency", 32'(cyc), 32'd2);
    check_eq("w8_sum", 32'(sum8), 32'h00);
    check_eq("w8_co", 32'(co8), 32'd1);
    check_eq("w8_ovf", 32'(ovf8), 32'd1);
`endif

    step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
